mips_main_control_fsm: RTL and testbench

//  Multicycle MIPS main control unit. Sequences each instruction through the

---
 rtl/mips_main_control_fsm.sv | 162 ++++++++++++++++
 tb/tb_mips_main_control_fsm.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mips_main_control_fsm.sv
// Multicycle MIPS main control: sequences fetch/decode/execute/memory/writeback
// and drives the datapath enables, stalling memory steps on mem_ready.
module mips_main_control_fsm #(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic [3:0] state,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  state_e state_q, state_d;
  logic   rdy;

  assign rdy   = MEM_WAIT_EN ? mem_ready : 1'b1;
  assign state = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = S_FETCH;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    ALUOp       = 2'b00;
    illegal_op  = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = rdy;
        PCWrite = rdy;
        state_d = rdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      illegal_op = 1'b1;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        state_d = rdy ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        state_d  = rdy ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
    // Reset overrides everything so no write strobe leaks while held
    if (reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      PCSource    = 2'b00;
      ALUOp       = 2'b00;
      illegal_op  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_main_control_fsm.sv
// Directed bench for mips_main_control_fsm: expected control vectors are
// queued per step and compared against the DUT at the falling edge.
module tb_mips_main_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
  logic [1:0] ALUSrcB, PCSource, ALUOp;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;
  int irw_cnt;

  logic [20:0] sb[$];

  localparam logic [5:0] R    = 6'b000000;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] J    = 6'b000010;
  localparam logic [5:0] ADDI = 6'b001000;

  mips_main_control_fsm #(.MEM_WAIT_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALUOp(ALUOp), .state(state), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  // Control table for each state, written straight from the state list
  function automatic logic [20:0] ev(input logic [3:0] st,
                                     input logic rdy, input logic ill);
    logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa;
    logic [1:0] sbs, ps, aop;
    {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa} = '0;
    sbs = 2'b00; ps = 2'b00; aop = 2'b00;
    case (st)
      4'd0:  begin mr = 1; sbs = 2'b01; pcw = rdy; irw = rdy; end
      4'd1:  sbs = 2'b11;
      4'd2:  begin sa = 1; sbs = 2'b10; end
      4'd3:  begin mr = 1; iord = 1; end
      4'd4:  begin rw = 1; m2r = 1; end
      4'd5:  begin mw = 1; iord = 1; end
      4'd6:  begin sa = 1; aop = 2'b10; end
      4'd7:  begin rw = 1; rd = 1; end
      4'd8:  begin sa = 1; aop = 2'b01; pcwc = 1; ps = 2'b01; end
      4'd9:  begin pcw = 1; ps = 2'b10; end
      4'd10: begin sa = 1; sbs = 2'b10; end
      4'd11: rw = 1;
      default: ;
    endcase
    return {st, pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa,
            sbs, ps, aop, ill};
  endfunction

  task automatic step(input string tag, input logic rst, input logic rdy,
                      input logic [5:0] op, input logic [3:0] st,
                      input logic ill);
    logic [20:0] got, exp;
    reset = rst; mem_ready = rdy; opcode = op;
    sb.push_back(rst ? 21'd0 : ev(st, rdy, ill));
    @(negedge clk);
    got = {state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource,
           ALUOp, illegal_op};
    exp = sb.pop_front();
    checks++;
    if (IRWrite) irw_cnt++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b1; opcode = R;
    #2;
    step("rst0", 1, 1, R, 0, 0);
    step("rst1", 1, 1, R, 0, 0);

    step("r_fetch", 0, 1, R, 0, 0);
    step("r_dec",   0, 1, R, 1, 0);
    step("r_exec",  0, 1, R, 6, 0);
    step("r_wb",    0, 1, R, 7, 0);

    irw_cnt = 0;
    step("lw_f_st0", 0, 0, LW, 0, 0);
    step("lw_f_st1", 0, 0, LW, 0, 0);
    step("lw_fetch", 0, 1, LW, 0, 0);
    step("lw_dec",   0, 1, LW, 1, 0);
    step("lw_adr",   0, 1, LW, 2, 0);
    step("lw_rd_s0", 0, 0, LW, 3, 0);
    step("lw_rd_s1", 0, 0, LW, 3, 0);
    step("lw_rd_s2", 0, 0, LW, 3, 0);
    step("lw_rd",    0, 1, LW, 3, 0);
    step("lw_wb",    0, 1, LW, 4, 0);
    checks++;
    assert (irw_cnt === 1) else begin
      errors++;
      $error("FAIL lw_irwrite_once: observed %0d expected 1", irw_cnt);
    end

    step("sw_fetch", 0, 1, SW, 0, 0);
    step("sw_dec",   0, 1, SW, 1, 0);
    step("sw_adr",   0, 1, SW, 2, 0);
    step("sw_wr_s0", 0, 0, SW, 5, 0);
    step("sw_wr_s1", 0, 0, SW, 5, 0);
    step("sw_wr",    0, 1, SW, 5, 0);

    step("beq_fetch", 0, 1, BEQ, 0, 0);
    step("beq_dec",   0, 1, BEQ, 1, 0);
    step("beq_br",    0, 1, BEQ, 8, 0);
    step("j_fetch",   0, 1, J, 0, 0);
    step("j_dec",     0, 1, J, 1, 0);
    step("j_jump",    0, 1, J, 9, 0);

    step("addi_fetch", 0, 1, ADDI, 0, 0);
    step("addi_dec",   0, 1, ADDI, 1, 0);
    step("addi_ex",    0, 1, ADDI, 10, 0);
    step("addi_wb",    0, 1, ADDI, 11, 0);

    step("ill_fetch", 0, 1, 6'b111111, 0, 0);
    step("ill_dec",   0, 1, 6'b111111, 1, 1);
    step("ill_back",  0, 1, R, 0, 0);
    step("r2_dec",    0, 1, R, 1, 0);
    step("r2_exec",   0, 1, R, 6, 0);
    step("r2_wb",     0, 1, R, 7, 0);
    step("jal_fetch", 0, 1, 6'b000011, 0, 0);
    step("jal_dec",   0, 1, 6'b000011, 1, 1);

    step("swr_fetch", 0, 1, SW, 0, 0);
    step("swr_dec",   0, 1, SW, 1, 0);
    step("swr_adr",   0, 1, SW, 2, 0);
    step("swr_wr_s",  0, 0, SW, 5, 0);
    step("swr_rst0",  1, 0, SW, 0, 0);
    step("swr_rst1",  1, 1, SW, 0, 0);
    step("swr_rel",   0, 0, SW, 0, 0);
    step("swr_fetch2", 0, 1, R, 0, 0);
    step("swr_dec2",   0, 1, R, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
